// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: receives a framed program image, writes it into instruction memory
// and holds the core in reset until the image's checksum has been verified.
module imem_boot_loader #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    localparam logic [ADDR_W-1:0] AddrMax = ADDR_W'(IMEM_DEPTH - 1);

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        acc_q, acc_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       word_q, word_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       loaded_q, loaded_d;
    logic              rx_ready_q, rx_ready_d;
    logic              accept;
    logic [15:0]       len_full;

    assign accept   = rx_valid && rx_ready_q;
    assign len_full = {rx_data, len_q[7:0]};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        acc_d      = acc_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        loaded_d   = loaded_q;

        // Address advances only after its write strobe, and saturates at the last word.
        if (we_q && (addr_q != AddrMax)) begin
            addr_d = addr_q + 1'b1;
        end

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d    = StLenLo;
                    len_d      = '0;
                    acc_d      = '0;
                    byte_idx_d = '0;
                    loaded_d   = '0;
                    addr_d     = '0;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d[7:0] = rx_data;
                    acc_d      = acc_q ^ rx_data;
                    state_d    = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d[15:8] = rx_data;
                    acc_d       = acc_q ^ rx_data;
                    if (32'(len_full) > IMEM_DEPTH) begin
                        state_d = StErr;
                    end else if (len_full == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    acc_d      = acc_q ^ rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    unique case (byte_idx_q)
                        2'd0: word_d[7:0]   = rx_data;
                        2'd1: word_d[15:8]  = rx_data;
                        2'd2: word_d[23:16] = rx_data;
                        2'd3: begin
                            we_d     = 1'b1;
                            wdata_d  = {rx_data, word_q};
                            loaded_d = loaded_q + 16'd1;
                            if ((loaded_q + 16'd1) == len_q) begin
                                state_d = StCsum;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StCsum: begin
                if (accept) begin
                    state_d = (rx_data == acc_q) ? StDone : StErr;
                end
            end
            default: state_d = StIdle;
        endcase

        rx_ready_d = (state_d == StLenLo) || (state_d == StLenHi) ||
                     (state_d == StData)  || (state_d == StCsum);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            len_q      <= '0;
            acc_q      <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            loaded_q   <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            loaded_q   <= loaded_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    always_comb begin
        rx_ready     = rx_ready_q;
        imem_we      = we_q;
        imem_addr    = addr_q;
        imem_wdata   = wdata_q;
        words_loaded = loaded_q;
        busy         = (state_q == StLenLo) || (state_q == StLenHi) ||
                       (state_q == StData)  || (state_q == StCsum);
        done         = (state_q == StDone);
        error        = (state_q == StErr);
        cpu_hold     = (state_q != StDone);
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader: framed loads, checksum/length errors,
// handshake gaps, ignored start and mid-frame reset.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    logic [7:0] frame2 [0:10] = '{8'h02, 8'h00, 8'hB3, 8'h01, 8'h22, 8'h00,
                                  8'h13, 8'h00, 8'h00, 8'h00, 8'h81};

    imem_boot_loader #(
        .IMEM_DEPTH(256)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Log every write strobe; a stretched pulse shows up as an extra entry.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_write(input int idx, input logic [7:0] a, input logic [31:0] d);
        if (idx < wr_addr.size()) begin
            check($sformatf("wr%0d_addr", idx), 32'(wr_addr[idx]), 32'(a));
            check($sformatf("wr%0d_data", idx), wr_data[idx], d);
        end else begin
            check($sformatf("wr%0d_present", idx), 32'(wr_addr.size()), 32'(idx + 1));
        end
    endtask

    // Entered and left on a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic check_status(input string tag, input logic b, input logic d, input logic e,
                                input logic h);
        check({tag, "_busy"}, 32'(busy), 32'(b));
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_error"}, 32'(error), 32'(e));
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // 1: reset values
        repeat (2) @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);

        // 2: good two-word image
        clear_log();
        pulse_start();
        check("t2_rx_ready", 32'(rx_ready), 32'd1);
        check_status("t2_run", 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) send_byte(frame2[i], 0);
        @(negedge clk);
        check_status("t2_end", 1'b0, 1'b1, 1'b0, 1'b0);
        check("t2_words_loaded", 32'(words_loaded), 32'd2);
        check("t2_n_writes", 32'(wr_addr.size()), 32'd2);
        check_write(0, 8'd0, 32'h002201B3);
        check_write(1, 8'd1, 32'h00000013);

        // 3: bad checksum, words still written
        clear_log();
        pulse_start();
        check("t3_restart_done", 32'(done), 32'd0);
        check("t3_restart_hold", 32'(cpu_hold), 32'd1);
        for (int i = 0; i < 10; i++) send_byte(frame2[i], 0);
        send_byte(8'h80, 0);
        @(negedge clk);
        check_status("t3_end", 1'b0, 1'b0, 1'b1, 1'b1);
        check("t3_words_loaded", 32'(words_loaded), 32'd2);
        check("t3_n_writes", 32'(wr_addr.size()), 32'd2);
        check_write(0, 8'd0, 32'h002201B3);
        check_write(1, 8'd1, 32'h00000013);

        // 4: empty image, then oversize length
        clear_log();
        pulse_start();
        check("t4a_error_cleared", 32'(error), 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        check_status("t4a_end", 1'b0, 1'b1, 1'b0, 1'b0);
        check("t4a_words_loaded", 32'(words_loaded), 32'd0);
        check("t4a_n_writes", 32'(wr_addr.size()), 32'd0);
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("t4b_rx_ready", 32'(rx_ready), 32'd0);
        check_status("t4b_end", 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("t4b_n_writes", 32'(wr_addr.size()), 32'd0);

        // 5: gaps in rx_valid plus an ignored start mid-frame
        clear_log();
        pulse_start();
        for (int i = 0; i < 11; i++) begin
            send_byte(frame2[i], int'($urandom_range(0, 3)));
            if (i == 4) begin
                pulse_start();
                check("t5_busy_after_start", 32'(busy), 32'd1);
                check("t5_loaded_kept", 32'(words_loaded), 32'd0);
            end
        end
        @(negedge clk);
        check_status("t5_end", 1'b0, 1'b1, 1'b0, 1'b0);
        check("t5_words_loaded", 32'(words_loaded), 32'd2);
        check("t5_n_writes", 32'(wr_addr.size()), 32'd2);
        check_write(0, 8'd0, 32'h002201B3);
        check_write(1, 8'd1, 32'h00000013);

        // 6: reset mid-word, then reload
        clear_log();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(frame2[i], 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_status("t6_rst", 1'b0, 1'b0, 1'b0, 1'b1);
        check("t6_rst_rx_ready", 32'(rx_ready), 32'd0);
        check("t6_rst_words_loaded", 32'(words_loaded), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_no_writes", 32'(wr_addr.size()), 32'd0);
        pulse_start();
        for (int i = 0; i < 11; i++) send_byte(frame2[i], 0);
        @(negedge clk);
        check_status("t6_end", 1'b0, 1'b1, 1'b0, 1'b0);
        check("t6_words_loaded", 32'(words_loaded), 32'd2);
        check("t6_n_writes", 32'(wr_addr.size()), 32'd2);
        check_write(0, 8'd0, 32'h002201B3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
